hc595_chain_drv: RTL and testbench
==================================

# hc595_chain_drv

Parametrised serial driver for a cascade of 74HC595 shift registers, generalising the fixed two-chip 595 output stage used behind the dynamic seven-segment scanner. It accepts a full-chain parallel word through a valid/ready handshake, shifts it out on `ds`/`shcp` at a programmable rate with selectable bit order, then pulses `stcp` to latch it. It also owns `oe` with a runtime blank control. It sits between the segment/digit formatter and the board pins.

## Interface
- `CHAIN_LEN`, 2: number of cascaded 8-bit 595s; ≥1; word width W = 8*CHAIN_LEN.
- `CLK_DIV`, 2: `sys_clk` cycles per `shcp` half-period, and `stcp` high time; ≥1.
- `MSB_FIRST`, 1: 1 = bit W-1 shifted first, 0 = bit 0 first.
- `sys_clk` in 1: single clock for the whole block.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `data_in` in W: word to display; bit W-1 ends in the far chip's Q7 when MSB_FIRST=1.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: block can accept a word.
- `oe_en` in 1: 1 = outputs enabled, 0 = blank.
- `shcp` out 1: 595 shift clock.
- `stcp` out 1: 595 storage/latch clock.
- `ds` out 1: serial data.
- `oe` out 1: 595 output enable, active-low.

## Operation
- All outputs are registered. Reset values: `shcp`=0, `stcp`=0, `ds`=0, `oe`=1, `data_ready`=0. Internal `loaded` flag=0.
- FSM: IDLE → SHIFT → LATCH → IDLE. Reset state is IDLE.
- `data_ready`=1 on the first cycle after reset release. Afterwards it is 1 exactly while the FSM is in IDLE.
- IDLE: on an edge with `data_valid && data_ready`, capture `data_in` into a W-bit shift register and clear `data_ready`. Set `ds` to the first bit, hold `shcp`=0, clear the divider and bit counter, then go to SHIFT. `data_in` is ignored at all other times.
- SHIFT: the divider counts 0..CLK_DIV-1; at terminal count `shcp` toggles.
  - On each 1→0 toggle, `ds` advances to the next bit in the same cycle. The bit counter counts rising edges.
  - After the W-th rising edge's high phase ends (`shcp` back to 0), `ds` holds its last value and the FSM goes to LATCH.
- LATCH: `stcp`=1 for CLK_DIV cycles, then `stcp`=0, `loaded`=1, `data_ready`=1, FSM to IDLE.
- `oe` = ~(`oe_en` & `loaded`), registered, so `oe` follows `oe_en` with one cycle of latency. Nothing enables before the first completed latch.
- `data_valid` deasserting mid-frame has no effect. A frame always completes.
- Reset asserted in any state: next edge returns all outputs to reset values. The partial frame is discarded and `loaded` is cleared, so the display blanks.

## Timing
- `ds` is stable ≥CLK_DIV cycles before and after every `shcp` rising edge.
- Frame length, measured from the first SHIFT cycle to the first IDLE cycle: 2*CLK_DIV*W + CLK_DIV cycles. With defaults this is 66.
- Back-to-back throughput is one word per 2*CLK_DIV*W + CLK_DIV + 1 cycles, because there is one IDLE cycle for the handshake.
- `stcp` never rises while `shcp`=1. `shcp` is 0 throughout LATCH and IDLE.
- Bit counter width is $clog2(W+1). The divider width is $clog2(CLK_DIV), minimum 1 bit. No wrap occurs inside a frame.

## Structure
- Shared package `hc595_pkg` holds:
  - the FSM state enum (IDLE, SHIFT, LATCH);
  - the 595 chip width constant (8);
  - an elaboration-time check function asserting CHAIN_LEN≥1 and CLK_DIV≥1.
- One sub-module, `hc595_tick_gen`: a restartable CLK_DIV divider with a `clr` input and a one-cycle `tick` output. It is used for both the `shcp` half-periods and the `stcp` pulse width.

## Test plan
- **Defaults, MSB_FIRST=1, word 16'hA55A with `oe_en`=1:**
  - 16 `shcp` rising edges sample `ds` = 1010_0101_0101_1010.
  - One `stcp` pulse of 2 cycles.
  - Frame is 66 cycles; `oe` falls 1 cycle after the latch ends.
- **MSB_FIRST=0, CHAIN_LEN=3, CLK_DIV=1, word 24'h0000_01:**
  - First sampled bit is 1, the remaining 23 bits are 0.
  - Frame is 49 cycles.
- **Handshake:** hold `data_valid`=1 with two successive words.
  - Exactly two frames.
  - `data_ready` low during each frame.
  - Second frame starts 67 cycles after the first accept.
  - A word changed mid-frame is not used.
- **Reset:** assert `sys_rst_n`=0 at bit 7 of a frame.
  - Next edge: `shcp`=`stcp`=`ds`=0, `oe`=1, `data_ready`=0.
  - After release, a new frame runs correctly from bit 0.
- **Blanking:** toggle `oe_en` 1→0→1 after a completed frame.
  - `oe` goes 1 then 0, each 1 cycle after the `oe_en` change.
  - Before any latch, `oe` stays 1 regardless of `oe_en`.

Source files
------------

// File: rtl/hc595_pkg.sv
// hc595_pkg: shared FSM states, chip width and parameter check for the 595 chain driver
package hc595_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;
  localparam int CHIP_W = 8;
  function automatic bit params_ok(input int chain_len, input int clk_div);
    return chain_len >= 1 && clk_div >= 1;
  endfunction
endpackage

// File: rtl/hc595_tick_gen.sv
// hc595_tick_gen: restartable divider producing a one-cycle tick every CLK_DIV cycles
module hc595_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] cnt_q, cnt_d;
  assign tick = ~clr & (cnt_q == DW'(CLK_DIV - 1));
  always_comb cnt_d = (clr | tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge sys_clk) cnt_q <= ~sys_rst_n ? '0 : cnt_d;
endmodule

// File: rtl/hc595_chain_drv.sv
// hc595_chain_drv: serialises a parallel word into a 74HC595 cascade and latches it
module hc595_chain_drv
  import hc595_pkg::*;
#(
  parameter int CHAIN_LEN = 2,
  parameter int CLK_DIV = 2,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W = CHIP_W * CHAIN_LEN
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [W-1:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic         oe_en,
  output logic         shcp,
  output logic         stcp,
  output logic         ds,
  output logic         oe
);
  localparam int BW = $clog2(W + 1);
  if (!params_ok(CHAIN_LEN, CLK_DIV)) begin : g_bad_params
    $error("hc595_chain_drv: CHAIN_LEN and CLK_DIV must be >= 1");
  end
  state_e state_q, state_d;
  logic [W-1:0] sr_q, sr_d, sr_nx;
  logic [BW-1:0] bit_q, bit_d;
  logic shcp_q, shcp_d, stcp_q, stcp_d, ds_q, ds_d, oe_q, oe_d;
  logic ready_q, ready_d, loaded_q, loaded_d;
  logic tick, accept;
  hc595_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (state_q == IDLE),
    .tick     (tick)
  );
  assign accept = (state_q == IDLE) & data_valid & ready_q;
  assign sr_nx = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bit_d = bit_q;
    shcp_d = shcp_q;
    stcp_d = stcp_q;
    ds_d = ds_q;
    ready_d = ready_q;
    loaded_d = loaded_q;
    oe_d = ~(oe_en & loaded_q);
    case (state_q)
      IDLE: begin
        ready_d = ~accept;
        if (accept) begin
          sr_d = data_in;
          ds_d = MSB_FIRST ? data_in[W-1] : data_in[0];
          shcp_d = 1'b0;
          bit_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: if (tick) begin
        shcp_d = ~shcp_q;
        if (!shcp_q) bit_d = bit_q + 1'b1;
        else if (bit_q == BW'(W)) begin
          stcp_d = 1'b1;
          state_d = LATCH;
        end else begin
          sr_d = sr_nx;
          ds_d = MSB_FIRST ? sr_nx[W-1] : sr_nx[0];
        end
      end
      LATCH: if (tick) begin
        stcp_d = 1'b0;
        loaded_d = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_q <= '0;
      shcp_q <= 1'b0;
      stcp_q <= 1'b0;
      ds_q <= 1'b0;
      oe_q <= 1'b1;
      ready_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      shcp_q <= shcp_d;
      stcp_q <= stcp_d;
      ds_q <= ds_d;
      oe_q <= oe_d;
      ready_q <= ready_d;
      loaded_q <= loaded_d;
    end
  end
  assign data_ready = ready_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign ds = ds_q;
  assign oe = oe_q;
endmodule

// File: tb/tb_hc595_chain_drv.sv
// tb_hc595_chain_drv: randomized self-checking bench for the 595 chain driver
module tb_hc595_chain_drv;
  logic clk = 1'b0, rst_n = 1'b0, oe_en = 1'b0, dv_a = 1'b0, dv_b = 1'b0;
  logic [23:0] din = '0;
  logic a_ready, a_shcp, a_stcp, a_ds, a_oe;
  logic b_ready, b_shcp, b_stcp, b_ds, b_oe;
  int n_cmp = 0, n_bad = 0;
  int len, first, pulses, hi, bad, min_st, nbits;
  logic [23:0] got;
  always #5 clk = ~clk;
  hc595_chain_drv #(.CHAIN_LEN(2), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(din[15:0]), .data_valid(dv_a), .data_ready(a_ready),
    .oe_en(oe_en), .shcp(a_shcp), .stcp(a_stcp), .ds(a_ds), .oe(a_oe)
  );
  hc595_chain_drv #(.CHAIN_LEN(3), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(din), .data_valid(dv_b), .data_ready(b_ready),
    .oe_en(oe_en), .shcp(b_shcp), .stcp(b_stcp), .ds(b_ds), .oe(b_oe)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // expected serial sequence, first shifted bit placed at position n-1
  function automatic logic [23:0] order(input logic [23:0] w, input int n, input bit msb);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = msb ? w[n-1-i] : w[i];
    return r;
  endfunction
  // observe one frame at negedges until data_ready returns high
  task automatic run(input bit sel, input int kick_at, input logic [23:0] kick_w, input bit kick_v);
    logic sh, st, d, r, p_sh, p_st, p_ds;
    int stable;
    got = '0; nbits = 0; len = 0; first = 0; pulses = 0; hi = 0; bad = 0; min_st = 1000; stable = 1000;
    p_sh = 1'b0; p_st = 1'b0; p_ds = sel ? b_ds : a_ds;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == kick_at) begin
        din = kick_w;
        if (sel) dv_b = kick_v; else dv_a = kick_v;
      end
      sh = sel ? b_shcp : a_shcp;
      st = sel ? b_stcp : a_stcp;
      d = sel ? b_ds : a_ds;
      r = sel ? b_ready : a_ready;
      stable = (d !== p_ds) ? 1 : stable + 1;
      if (sh && !p_sh) begin
        got = {got[22:0], d};
        nbits++;
        if (stable - 1 < min_st) min_st = stable - 1;
      end
      if (sh && p_sh && d !== p_ds) bad++;
      if (st && !p_st) pulses++;
      if (st) hi++;
      if (st && sh) bad++;
      if (!r) begin
        if (first == 0) first = c;
        len++;
      end else if (len > 0) return;
      p_sh = sh; p_st = st; p_ds = d;
    end
    len = -1;
  endtask
  task automatic wait_ready(input bit sel);
    for (int c = 0; c < 300; c++) begin
      if (sel ? b_ready : a_ready) return;
      @(negedge clk);
    end
    chk("ready_timeout", 0, 1);
  endtask
  task automatic go(input bit sel, input logic [23:0] w);
    wait_ready(sel);
    din = w;
    if (sel) dv_b = 1'b1; else dv_a = 1'b1;
    run(sel, 1, w, 1'b0);
  endtask
  task automatic check_frame(input string tag, input logic [23:0] w, input int n, input bit msb, input int cd);
    chk({tag, "_len"}, len, 2 * cd * n + cd);
    chk({tag, "_nbits"}, nbits, n);
    chk({tag, "_bits"}, got, order(w, n, msb));
    chk({tag, "_stcp_pulses"}, pulses, 1);
    chk({tag, "_stcp_high"}, hi, cd);
    chk({tag, "_shape"}, bad, 0);
    chk({tag, "_ds_setup"}, min_st >= cd, 1);
  endtask
  initial begin
    logic [15:0] w1, w2, w3;
    int len1, idle_bad;
    oe_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_shcp", a_shcp, 0);
    chk("rst_stcp", a_stcp, 0);
    chk("rst_ds", a_ds, 0);
    chk("rst_oe", a_oe, 1);
    chk("rst_ready", a_ready, 0);
    chk("rst_ready_b", b_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", a_ready, 1);
    chk("oe_preload_en1", a_oe, 1);
    oe_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("oe_preload_en0", a_oe, 1);
    oe_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("oe_preload_en1b", a_oe, 1);
    go(1'b0, 24'h00A55A);
    check_frame("a55a", 24'h00A55A, 16, 1'b1, 2);
    chk("oe_at_latch_end", a_oe, 1);
    @(negedge clk);
    chk("oe_after_latch", a_oe, 0);
    oe_en = 1'b0;
    #1 chk("blank_before_edge", a_oe, 0);
    @(posedge clk); #1 chk("blank_after_edge", a_oe, 1);
    @(negedge clk);
    oe_en = 1'b1;
    #1 chk("unblank_before_edge", a_oe, 1);
    @(posedge clk); #1 chk("unblank_after_edge", a_oe, 0);
    @(negedge clk);
    go(1'b1, 24'h000001);
    check_frame("b_one", 24'h000001, 24, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      w1 = 16'($urandom);
      go(1'b0, {8'h00, w1});
      check_frame("a_rand", {8'h00, w1}, 16, 1'b1, 2);
    end
    for (int k = 0; k < 2; k++) begin
      logic [23:0] wb;
      wb = 24'($urandom);
      go(1'b1, wb);
      check_frame("b_rand", wb, 24, 1'b0, 1);
    end
    w1 = 16'($urandom);
    w2 = ~w1;
    w3 = w1 ^ 16'h5A5A;
    wait_ready(1'b0);
    din = {8'h00, w1};
    dv_a = 1'b1;
    run(1'b0, 10, {8'h00, w2}, 1'b1);
    check_frame("hs1", {8'h00, w1}, 16, 1'b1, 2);
    len1 = len;
    run(1'b0, 10, {8'h00, w3}, 1'b0);
    check_frame("hs2", {8'h00, w2}, 16, 1'b1, 2);
    chk("hs_accept_gap", len1 + first, 2 * 2 * 16 + 2 + 1);
    idle_bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!a_ready || a_shcp || a_stcp) idle_bad++;
    end
    chk("hs_no_third_frame", idle_bad, 0);
    w1 = 16'($urandom) | 16'h0100;
    din = {8'h00, w1};
    dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_frame_bit7", a_ds, w1[8]);
    chk("mid_frame_oe", a_oe, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_shcp", a_shcp, 0);
    chk("mid_rst_stcp", a_stcp, 0);
    chk("mid_rst_ds", a_ds, 0);
    chk("mid_rst_oe", a_oe, 1);
    chk("mid_rst_ready", a_ready, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_oe_blank", a_oe, 1);
    w2 = 16'($urandom);
    go(1'b0, {8'h00, w2});
    check_frame("post_rst", {8'h00, w2}, 16, 1'b1, 2);
    @(negedge clk);
    chk("post_rst_oe_on", a_oe, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
